// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SERIAL_SUB_WIDTH_DEF = 4;

    // Bits needed to count 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// Combinational 1-bit full subtractor: d = a - b - bi, bo is the borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference bit and borrow-out for one bit position.
    always_comb begin
        d  = a ^ b ^ bi;
        bo = (~a & b) | (~(a ^ b) & bi);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes ina - inb - bin LSB first over WIDTH cycles
// behind a start/done handshake.
// Optional macro SERIAL_SUB_SAT_EN: when defined, a final borrow forces diff to 0
// (saturating subtract); bout still reports the borrow.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic [WIDTH-1:0] d_next;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             brw_n;
    logic             d_bit;
    logic             last;

    full_sub u_full_sub (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (brw),
        .d  (d_bit),
        .bo (brw_n)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // The new difference bit enters at the MSB; a 1-bit result is just that bit.
    generate
        if (WIDTH == 1) begin : g_w1
            assign d_next = d_bit;
        end else begin : g_wn
            assign d_next = {d_bit, d_sr[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: start is only honoured in IDLE, DONE always returns to IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   if (last)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Status outputs decode straight from the state flops.
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Operand capture, serial shifting and the held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_sr <= ina;
                b_sr <= inb;
                brw  <= bin;
                cnt  <= '0;
                d_sr <= '0;
            end else if (state == SHIFT) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                brw  <= brw_n;
                d_sr <= d_next;
                cnt  <= cnt + CW'(1);
                if (last) begin
`ifdef SERIAL_SUB_SAT_EN
                    diff <= brw_n ? '0 : d_next;
`else
                    diff <= d_next;
`endif
                    bout <= brw_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed vectors feed a scoreboard queue,
// a monitor pops and compares on every done pulse.
module tb_serial_sub;

    typedef struct packed {
        logic       bout;
        logic [3:0] diff;
    } exp_t;

`ifdef SERIAL_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] ina;
    logic [3:0] inb;
    logic       bin;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       bout;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   done_total;
    int   cycle;
    int   start_cycle;

    serial_sub #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ina   (ina),
        .inb   (inb),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for latency and spacing measurements.
    always @(posedge clk) cycle++;

    // Apply the saturating rule to a hand-computed wrapped result.
    function automatic exp_t make_exp(input logic [3:0] d, input logic b);
        exp_t e;
        e.bout = b;
        e.diff = (b && SAT) ? 4'h0 : d;
        return e;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            exp_t e;
            done_total++;
            if (exp_q.size() == 0) begin
                check_output("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_output("diff", int'(diff), int'(e.diff));
                check_output("bout", int'(bout), int'(e.bout));
            end
        end
    end

    // Issue one start pulse; returns #1 after the accepting edge.
    task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input logic bi,
                                  input logic [3:0] d, input logic bo, input bit push);
        ina   = a;
        inb   = b;
        bin   = bi;
        start = 1'b1;
        if (push) exp_q.push_back(make_exp(d, bo));
        @(posedge clk);
        #1;
        start_cycle = cycle;
        start = 1'b0;
    endtask

    // Wait for done, counting edges since the start edge and cycles with busy high.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && edges < 20) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (done !== 1'b1) check_output("done_timeout", 0, 1);
    endtask

    // Wait for done and then step into the following IDLE cycle.
    task automatic finish_op();
        int e;
        int bc;
        wait_done(e, bc);
        @(posedge clk);
        #1;
    endtask

    // Hand-computed wrapped results for the back-to-back run: {a, b, bin, diff, bout}.
    logic [3:0] tv_a [16] = '{4'h1, 4'h0, 4'h8, 4'h8, 4'hF, 4'hF, 4'h7, 4'hA,
                              4'h5, 4'hC, 4'h2, 4'h6, 4'hD, 4'h4, 4'hB, 4'hE};
    logic [3:0] tv_b [16] = '{4'h0, 4'h1, 4'h8, 4'h8, 4'h0, 4'h1, 4'h8, 4'h5,
                              4'hA, 4'h3, 4'h2, 4'hE, 4'h4, 4'hD, 4'hB, 4'hF};
    logic       tv_i [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] tv_d [16] = '{4'h1, 4'hF, 4'h0, 4'hF, 4'hE, 4'hE, 4'hF, 4'h5,
                              4'hB, 4'h8, 4'hF, 4'h7, 4'h9, 4'h6, 4'h0, 4'hF};
    logic       tv_o [16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Hard stop in case the whole run stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int edges;
        int bcnt;
        int done_before;
        int prev_start;

        vectors     = 0;
        miscompares = 0;
        done_total  = 0;
        cycle       = 0;
        rst_n = 1'b0;
        start = 1'b0;
        ina   = '0;
        inb   = '0;
        bin   = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_done", int'(done), 0);
        check_output("reset_diff", int'(diff), 0);
        check_output("reset_bout", int'(bout), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic subtract with latency and busy length.
        apply_stimulus(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
        wait_done(edges, bcnt);
        check_output("latency", edges, 4);
        check_output("busy_cycles", bcnt, 4);
        @(posedge clk);
        #1;

        // Underflow.
        apply_stimulus(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
        finish_op();

        // Borrow-in chain.
        apply_stimulus(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b1);
        finish_op();
        apply_stimulus(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b1);
        finish_op();

        // Start held high with new operands through SHIFT and DONE is ignored.
        done_before = done_total;
        ina   = 4'hC;
        inb   = 4'h5;
        bin   = 1'b0;
        start = 1'b1;
        exp_q.push_back(make_exp(4'h7, 1'b0));
        @(posedge clk);
        #1;
        ina = 4'h7;
        inb = 4'h7;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_output("ignored_done_count", done_total - done_before, 1);
        check_output("ignored_busy_idle", int'(busy), 0);
        check_output("hold_diff", int'(diff), 7);
        check_output("hold_bout", int'(bout), 0);

        // Reset two cycles into an operation aborts it.
        done_before = done_total;
        apply_stimulus(4'h9, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_done", int'(done), 0);
        check_output("abort_diff", int'(diff), 0);
        check_output("abort_bout", int'(bout), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_output("abort_no_done", done_total - done_before, 0);
        apply_stimulus(4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b1);
        finish_op();

        // Back-to-back operations, each started in the first IDLE cycle.
        prev_start = 0;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(tv_a[i], tv_b[i], tv_i[i], tv_d[i], tv_o[i], 1'b1);
            if (i > 0) check_output("spacing", start_cycle - prev_start, 6);
            prev_start = start_cycle;
            finish_op();
        end

        repeat (3) @(posedge clk);
        #1;
        check_output("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
